// File: rtl/pipe_downsizer_pkg.sv
// pipe_downsizer_pkg
//   Shared type for the width-downsizing pipe stage.
//   state_e : one-bit occupancy flag of the stage.
//             ST_IDLE means no word is held.
//             ST_SEND means a word is held and its beats are being emitted.
package pipe_downsizer_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_e;

endpackage : pipe_downsizer_pkg

// File: rtl/pipe_downsizer.sv
// pipe_downsizer
//   Accepts one IN_WIDTH word and emits it as 1..RATIO beats of OUT_WIDTH
//   bits, least-significant lane first. The upstream side tells the stage
//   how many beats to emit with pipe_in_beats (beats minus one).
//   Back-to-back words stream with no bubble: a new word is taken in the
//   same cycle that the last beat of the current word is accepted.
//
// Ports
//   clk            in   single clock, rising edge
//   reset          in   synchronous active-high reset
//   pipe_in_valid  in   upstream word offered
//   pipe_in_data   in   upstream word [IN_WIDTH]
//   pipe_in_beats  in   number of beats minus one [CNT_W]
//   pipe_in_ready  out  word accepted this cycle when valid is also high
//   pipe_out_valid out  beat offered
//   pipe_out_data  out  current beat [OUT_WIDTH]
//   pipe_out_last  out  current beat is the final beat of its word
//   pipe_out_ready in   downstream accepts the beat this cycle
module pipe_downsizer
  import pipe_downsizer_pkg::*;
#(
  parameter int IN_WIDTH  = 256,
  parameter int OUT_WIDTH = 64,
  localparam int RATIO    = IN_WIDTH / OUT_WIDTH,
  localparam int CNT_W    = $clog2(RATIO)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 pipe_in_valid,
  input  logic [IN_WIDTH-1:0]  pipe_in_data,
  input  logic [CNT_W-1:0]     pipe_in_beats,
  output logic                 pipe_in_ready,
  output logic                 pipe_out_valid,
  output logic [OUT_WIDTH-1:0] pipe_out_data,
  output logic                 pipe_out_last,
  input  logic                 pipe_out_ready
);

  // State: occupancy flag plus beat index.
  state_e               state_q, state_d;
  logic [CNT_W-1:0]     idx_q, idx_d;

  // Held word and its beat count; only meaningful while state_q == ST_SEND,
  // so they are left out of reset.
  logic [IN_WIDTH-1:0]  data_q, data_d;
  logic [CNT_W-1:0]     beats_q, beats_d;

  logic                 in_hs;
  logic                 out_hs;

  // Lane view of the held word so the beat mux is a plain array index.
  logic [OUT_WIDTH-1:0] lanes [RATIO];

  for (genvar gi = 0; gi < RATIO; gi++) begin : g_lane
    assign lanes[gi] = data_q[gi*OUT_WIDTH +: OUT_WIDTH];
  end

  // Outputs come straight from state flops (no input-to-output paths),
  // except pipe_in_ready which must see pipe_out_ready to allow streaming.
  always_comb begin
    pipe_out_valid = (state_q == ST_SEND);
    pipe_out_last  = pipe_out_valid && (idx_q == beats_q);
    pipe_out_data  = lanes[idx_q];
    // Never looks at pipe_in_valid, so no valid/ready combinational loop.
    pipe_in_ready  = !pipe_out_valid || (pipe_out_last && pipe_out_ready);
  end

  assign in_hs  = pipe_in_valid && pipe_in_ready;
  assign out_hs = pipe_out_valid && pipe_out_ready;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    data_d  = data_q;
    beats_d = beats_q;
    if (in_hs) begin
      // Covers both the IDLE load and the load that overlaps the last beat.
      state_d = ST_SEND;
      idx_d   = '0;
      data_d  = pipe_in_data;
      beats_d = pipe_in_beats;
    end else if (out_hs) begin
      if (pipe_out_last) begin
        state_d = ST_IDLE;
        idx_d   = '0;
      end else begin
        idx_d = idx_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  always_ff @(posedge clk) begin
    data_q  <= data_d;
    beats_q <= beats_d;
  end

endmodule : pipe_downsizer

// File: tb/tb_pipe_downsizer.sv
// Self-checking bench for pipe_downsizer with default widths (256 -> 64).
module tb_pipe_downsizer;

  localparam int IW = 256;
  localparam int OW = 64;
  localparam int NWORDS = 10000;

  logic          clk = 1'b0;
  logic          reset;
  logic          pipe_in_valid;
  logic [IW-1:0] pipe_in_data;
  logic [1:0]    pipe_in_beats;
  logic          pipe_in_ready;
  logic          pipe_out_valid;
  logic [OW-1:0] pipe_out_data;
  logic          pipe_out_last;
  logic          pipe_out_ready;

  pipe_downsizer #(.IN_WIDTH(IW), .OUT_WIDTH(OW)) dut (
    .clk            (clk),
    .reset          (reset),
    .pipe_in_valid  (pipe_in_valid),
    .pipe_in_data   (pipe_in_data),
    .pipe_in_beats  (pipe_in_beats),
    .pipe_in_ready  (pipe_in_ready),
    .pipe_out_valid (pipe_out_valid),
    .pipe_out_data  (pipe_out_data),
    .pipe_out_last  (pipe_out_last),
    .pipe_out_ready (pipe_out_ready)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic          in_valid;
    logic [IW-1:0] in_data;
    logic [1:0]    in_beats;
    logic          out_ready;
    logic          e_valid;
    logic [OW-1:0] e_data;
    logic          e_last;
    logic          e_in_ready;
  } vec_t;

  typedef struct {
    logic [OW-1:0] d;
    logic          l;
  } beat_t;

  vec_t  vecs[$];
  beat_t sb[$];

  task automatic check(input string name, input logic [OW-1:0] act, input logic [OW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(logic iv, logic [IW-1:0] d, logic [1:0] b, logic ordy,
                              logic ev, logic [OW-1:0] ed, logic el, logic eir);
    vec_t v;
    v.in_valid = iv; v.in_data = d; v.in_beats = b; v.out_ready = ordy;
    v.e_valid = ev; v.e_data = ed; v.e_last = el; v.e_in_ready = eir;
    return v;
  endfunction

  logic [IW-1:0] w_main, w_aa, w_a, w_b, w_junk, w_r, cur;
  logic [1:0]    cur_b;
  bit            have;
  int            sent;
  int            cyc;
  beat_t         bt;

  initial begin
    w_main = {64'd4, 64'd3, 64'd2, 64'd1};
    w_aa   = {64'h5555, 64'h5555, 64'h5555, 64'hAA};
    w_a    = {64'h14, 64'h13, 64'h12, 64'h11};
    w_b    = {64'h24, 64'h23, 64'h22, 64'h21};
    w_junk = {64'hDEAD, 64'hBEEF, 64'hCAFE, 64'hF00D};
    w_r    = {64'h34, 64'h33, 64'h32, 64'h31};

    // Four beats on consecutive cycles, last only on beat 4.
    vecs.push_back(mk(1, w_main, 2'd3, 1, 0, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 1, 1, 64'd1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 1, 64'd2, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 1, 64'd3, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 1, 64'd4, 1, 1));
    vecs.push_back(mk(0, 0, 0, 1, 0, 0, 0, 1));
    // Single beat word: upper lanes dropped.
    vecs.push_back(mk(1, w_aa, 2'd0, 1, 0, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 1, 1, 64'hAA, 1, 1));
    vecs.push_back(mk(0, 0, 0, 1, 0, 0, 0, 1));
    // Two 2-beat words back to back, valid held high.
    vecs.push_back(mk(1, w_a, 2'd1, 1, 0, 0, 0, 1));
    vecs.push_back(mk(1, w_b, 2'd1, 1, 1, 64'h11, 0, 0));
    vecs.push_back(mk(1, w_b, 2'd1, 1, 1, 64'h12, 1, 1));
    vecs.push_back(mk(0, 0, 0, 1, 1, 64'h21, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 1, 64'h22, 1, 1));
    vecs.push_back(mk(0, 0, 0, 1, 0, 0, 0, 1));
    // Stalls with ready pattern 1,0,0,1,...; a pending word must not be taken.
    vecs.push_back(mk(1, w_main, 2'd3, 1, 0, 0, 0, 1));
    vecs.push_back(mk(1, w_junk, 2'd3, 1, 1, 64'd1, 0, 0));
    vecs.push_back(mk(1, w_junk, 2'd3, 0, 1, 64'd2, 0, 0));
    vecs.push_back(mk(1, w_junk, 2'd3, 0, 1, 64'd2, 0, 0));
    vecs.push_back(mk(1, w_junk, 2'd3, 1, 1, 64'd2, 0, 0));
    vecs.push_back(mk(1, w_junk, 2'd3, 0, 1, 64'd3, 0, 0));
    vecs.push_back(mk(1, w_junk, 2'd3, 0, 1, 64'd3, 0, 0));
    vecs.push_back(mk(1, w_junk, 2'd3, 1, 1, 64'd3, 0, 0));
    vecs.push_back(mk(1, w_junk, 2'd3, 0, 1, 64'd4, 1, 0));
    vecs.push_back(mk(1, w_junk, 2'd3, 0, 1, 64'd4, 1, 0));
    vecs.push_back(mk(0, 0, 0, 1, 1, 64'd4, 1, 1));
    vecs.push_back(mk(0, 0, 0, 1, 0, 0, 0, 1));

    // Reset and reset-state checks.
    reset = 1; pipe_in_valid = 0; pipe_in_data = '0; pipe_in_beats = '0; pipe_out_ready = 0;
    tick(); tick();
    reset = 0;
    #1;
    check("rst.valid", 64'(pipe_out_valid), 64'd0);
    check("rst.last", 64'(pipe_out_last), 64'd0);
    check("rst.in_ready", 64'(pipe_in_ready), 64'd1);
    tick();

    // Table-driven vectors: one cycle each.
    foreach (vecs[i]) begin
      pipe_in_valid  = vecs[i].in_valid;
      pipe_in_data   = vecs[i].in_data;
      pipe_in_beats  = vecs[i].in_beats;
      pipe_out_ready = vecs[i].out_ready;
      #1;
      check($sformatf("vec%0d.valid", i), 64'(pipe_out_valid), 64'(vecs[i].e_valid));
      check($sformatf("vec%0d.last", i), 64'(pipe_out_last), 64'(vecs[i].e_last));
      check($sformatf("vec%0d.in_ready", i), 64'(pipe_in_ready), 64'(vecs[i].e_in_ready));
      if (vecs[i].e_valid)
        check($sformatf("vec%0d.data", i), pipe_out_data, vecs[i].e_data);
      tick();
    end

    // Reset in the middle of a word abandons the remaining beats.
    pipe_in_valid = 1; pipe_in_data = w_main; pipe_in_beats = 2'd3; pipe_out_ready = 1;
    tick();
    pipe_in_valid = 0;
    #1;
    check("mid.beat1", pipe_out_data, 64'd1);
    tick();
    #1;
    check("mid.beat2", pipe_out_data, 64'd2);
    tick();
    reset = 1;
    tick();
    reset = 0;
    #1;
    check("mid.rst.valid", 64'(pipe_out_valid), 64'd0);
    check("mid.rst.last", 64'(pipe_out_last), 64'd0);
    check("mid.rst.in_ready", 64'(pipe_in_ready), 64'd1);
    pipe_in_valid = 1; pipe_in_data = w_r; pipe_in_beats = 2'd3;
    tick();
    pipe_in_valid = 0;
    #1;
    check("mid.new.valid", 64'(pipe_out_valid), 64'd1);
    check("mid.new.lane0", pipe_out_data, 64'h31);
    for (int k = 0; k < 4; k++) tick();
    #1;
    check("mid.new.idle", 64'(pipe_out_valid), 64'd0);

    // Random traffic against a beat scoreboard.
    have = 0; sent = 0; cyc = 0;
    while (cyc < 80000) begin
      tick();
      cyc++;
      if (!have && sent < NWORDS && $urandom_range(0, 3) != 0) begin
        for (int k = 0; k < IW / 32; k++) cur[k*32 +: 32] = $urandom;
        cur_b = 2'($urandom_range(0, 3));
        have = 1;
      end
      pipe_in_valid  = have;
      pipe_in_data   = have ? cur : '0;
      pipe_in_beats  = have ? cur_b : 2'd0;
      pipe_out_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (pipe_out_valid && pipe_out_ready) begin
        if (sb.size() == 0) begin
          check("rnd.unexpected_beat", 64'd1, 64'd0);
        end else begin
          bt = sb.pop_front();
          check("rnd.data", pipe_out_data, bt.d);
          check("rnd.last", 64'(pipe_out_last), 64'(bt.l));
        end
      end
      if (pipe_in_valid && pipe_in_ready) begin
        for (int k = 0; k <= int'(cur_b); k++) begin
          bt.d = cur[k*OW +: OW];
          bt.l = (k == int'(cur_b));
          sb.push_back(bt);
        end
        have = 0;
        sent++;
      end
      if (sent == NWORDS && sb.size() == 0) break;
    end
    check("rnd.words_sent", 64'(sent), 64'(NWORDS));
    check("rnd.leftover_beats", 64'(sb.size()), 64'd0);
    pipe_in_valid = 0;
    tick();
    #1;
    check("rnd.final_idle", 64'(pipe_out_valid), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_pipe_downsizer
